// File: rtl/ahfp_floor_arbiter.sv
// Two-requester front end for one shared IEEE-754 single-precision floor unit.
// Each requester owns a one-deep pending slot; a small FSM grants, executes and returns results.
module ahfp_floor_arbiter #(
  parameter int unsigned LATENCY     = 2,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        req0_start,
  input  logic [31:0] req0_dataa,
  output logic        req0_done,
  output logic [31:0] req0_result,
  input  logic        req1_start,
  input  logic [31:0] req1_dataa,
  output logic        req1_done,
  output logic [31:0] req1_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  function automatic logic [31:0] fp_floor(input logic [31:0] d);
    logic [7:0]  e;
    logic [22:0] m;
    logic [4:0]  sh;
    e  = d[30:23];
    m  = d[22:0];
    sh = 5'(8'd150 - e);
    if (d[31] || (e < 8'd127)) return 32'h0000_0000;
    else if (e <= 8'd149)      return {1'b0, e, m & (23'h7F_FFFF << sh)};
    else                       return {1'b0, e, m};
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        turn_q, turn_d;
  logic        pend0_q, pend0_d;
  logic        pend1_q, pend1_d;
  logic [31:0] opnd0_q, opnd0_d;
  logic [31:0] opnd1_q, opnd1_d;
  logic [31:0] op_q, op_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [31:0] result0_q, result0_d;
  logic [31:0] result1_q, result1_d;

  logic        accept0, accept1, pick1;
  logic [31:0] floor_out;

  // A start is taken into an empty slot, or into the slot being returned this cycle.
  assign accept0   = clk_en & req0_start & (~pend0_q | done0_q);
  assign accept1   = clk_en & req1_start & (~pend1_q | done1_q);
  assign pick1     = pend1_q & (~pend0_q | (ROUND_ROBIN & ~last_grant_q));
  assign floor_out = fp_floor(op_q);

  // NOTE: every *_d starts at its held value, so no path through this block infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    turn_d       = turn_q;
    pend0_d      = pend0_q;
    pend1_d      = pend1_q;
    opnd0_d      = opnd0_q;
    opnd1_d      = opnd1_q;
    op_d         = op_q;
    done0_d      = done0_q;
    done1_d      = done1_q;
    result0_d    = result0_q;
    result1_d    = result1_q;

    if (clk_en) begin
      done0_d = 1'b0;
      done1_d = 1'b0;
      turn_d  = 1'b0;
      pend0_d = accept0 | (pend0_q & ~done0_q);
      pend1_d = accept1 | (pend1_q & ~done1_q);
      if (accept0) opnd0_d = req0_dataa;
      if (accept1) opnd1_d = req1_dataa;

      case (state_q)
        ST_IDLE: begin
          // The cycle right after a return is a turnaround: no grant is issued in it.
          if (!turn_q && (pend0_q || pend1_q)) begin
            grant_d = pick1;
            op_d    = pick1 ? opnd1_q : opnd0_q;
            cnt_d   = CNT_INIT;
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == 3'd0) begin
            if (grant_q) begin
              result1_d = floor_out;
              done1_d   = 1'b1;
            end else begin
              result0_d = floor_out;
              done0_d   = 1'b1;
            end
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_DONE: begin
          last_grant_d = grant_q;
          turn_d       = 1'b1;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      turn_q       <= 1'b0;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      opnd0_q      <= 32'h0;
      opnd1_q      <= 32'h0;
      op_q         <= 32'h0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      result0_q    <= 32'h0;
      result1_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      turn_q       <= turn_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
      opnd0_q      <= opnd0_d;
      opnd1_q      <= opnd1_d;
      op_q         <= op_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      result0_q    <= result0_d;
      result1_q    <= result1_d;
    end
  end

  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign req0_result = result0_q;
  assign req1_result = result1_q;
  assign busy        = (state_q != ST_IDLE) | pend0_q | pend1_q;

endmodule

// File: tb/tb_ahfp_floor_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share stimulus;
// expected returns are queued by the stimulus and retired by a negedge monitor.
module tb_ahfp_floor_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        req0_start = 1'b0;
  logic        req1_start = 1'b0;
  logic [31:0] req0_dataa = 32'h0;
  logic [31:0] req1_dataa = 32'h0;

  logic        rr_done0, rr_done1, rr_busy;
  logic [31:0] rr_res0, rr_res1;
  logic        fp_done0, fp_done1, fp_busy;
  logic [31:0] fp_res0, fp_res1;

  ahfp_floor_arbiter #(.LATENCY(LAT), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .req0_start(req0_start), .req0_dataa(req0_dataa), .req0_done(rr_done0), .req0_result(rr_res0),
    .req1_start(req1_start), .req1_dataa(req1_dataa), .req1_done(rr_done1), .req1_result(rr_res1),
    .busy(rr_busy)
  );

  ahfp_floor_arbiter #(.LATENCY(LAT), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .req0_start(req0_start), .req0_dataa(req0_dataa), .req0_done(fp_done0), .req0_result(fp_res0),
    .req1_start(req1_start), .req1_dataa(req1_dataa), .req1_done(fp_done1), .req1_result(fp_res1),
    .busy(fp_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    int          at;
    logic [31:0] res;
  } exp_t;

  exp_t        q_rr[$];
  exp_t        q_fp[$];
  logic [31:0] model[2][2];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic monitor(input int inst, input logic d0, input logic d1,
                         input logic [31:0] r0, input logic [31:0] r1);
    exp_t  e;
    string tag;
    int    ch;
    bit    empty;
    tag = (inst == 0) ? "rr" : "fp";
    if (d0 || d1) begin
      check({tag, "_one_done_at_a_time"}, 32'(d0 & d1), 32'h0);
      ch    = d1 ? 1 : 0;
      empty = (inst == 0) ? (q_rr.size() == 0) : (q_fp.size() == 0);
      if (empty) begin
        check({tag, "_unexpected_done"}, 32'(d0 | d1), 32'h0);
      end else begin
        if (inst == 0) e = q_rr.pop_front();
        else           e = q_fp.pop_front();
        check({tag, "_done_channel"}, 32'(ch), 32'(e.ch));
        check({tag, "_done_cycle"}, 32'(cyc), 32'(e.at));
        check({tag, "_result"}, (ch == 1) ? r1 : r0, e.res);
        model[inst][ch] = e.res;
        check({tag, "_other_result_held"}, (ch == 1) ? r0 : r1, model[inst][1-ch]);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0, rr_done0, rr_done1, rr_res0, rr_res1);
    monitor(1, fp_done0, fp_done1, fp_res0, fp_res1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_on(input int inst, input int ch, input int at, input logic [31:0] res);
    exp_t e;
    e.ch  = ch;
    e.at  = at;
    e.res = res;
    if (inst == 0) q_rr.push_back(e);
    else           q_fp.push_back(e);
  endtask

  task automatic expect_both(input int ch, input int at, input logic [31:0] res);
    expect_on(0, ch, at, res);
    expect_on(1, ch, at, res);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) model[i][j] = 32'h0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rr_busy"}, 32'(rr_busy), 32'h0);
    check({tag, "_rr_done0"}, 32'(rr_done0), 32'h0);
    check({tag, "_rr_done1"}, 32'(rr_done1), 32'h0);
    check({tag, "_rr_res0"}, rr_res0, 32'h0);
    check({tag, "_rr_res1"}, rr_res1, 32'h0);
    check({tag, "_fp_busy"}, 32'(fp_busy), 32'h0);
    check({tag, "_fp_res0"}, fp_res0, 32'h0);
    check({tag, "_fp_res1"}, fp_res1, 32'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_model();
    tick(2);
    check_cleared("reset");
    reset_n = 1'b1;
    tick(1);
  endtask

  logic [31:0] corner_in[4];
  logic [31:0] corner_exp[4];

  initial begin
    int c;
    corner_in  = '{32'hC020_0000, 32'h3F00_0000, 32'h40F8_0000, 32'h4B7F_FFFF};
    corner_exp = '{32'h0000_0000, 32'h0000_0000, 32'h40E0_0000, 32'h4B7F_FFFF};
    clear_model();
    tick(1);
    do_reset();
    check_cleared("post_reset");

    // Single op on requester 0, with busy traced cycle by cycle.
    c = cyc;
    req0_dataa = 32'h4049_0FDB;
    req0_start = 1'b1;
    expect_both(0, c + LAT + 2, 32'h4040_0000);
    check("busy_cycle0", 32'(rr_busy), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      req0_start = 1'b0;
      check("busy_single_op", 32'(rr_busy), 32'(k <= LAT + 2));
    end

    // Corner operands on requester 1, one at a time.
    for (int i = 0; i < 4; i++) begin
      c = cyc;
      req1_dataa = corner_in[i];
      req1_start = 1'b1;
      expect_both(1, c + LAT + 2, corner_exp[i]);
      tick(1);
      req1_start = 1'b0;
      tick(5);
    end

    // Simultaneous starts straight after reset: requester 0 first on both arbiters.
    do_reset();
    c = cyc;
    req0_dataa = 32'h40F8_0000;
    req1_dataa = 32'h4049_0FDB;
    req0_start = 1'b1;
    req1_start = 1'b1;
    expect_both(0, c + 4, 32'h40E0_0000);
    expect_both(1, c + 9, 32'h4040_0000);
    tick(1);
    req0_start = 1'b0;
    req1_start = 1'b0;
    tick(11);

    // Leave requester 0 as last grant, then tie again.
    c = cyc;
    req0_dataa = 32'h422A_CCCD;
    req0_start = 1'b1;
    expect_both(0, c + 4, 32'h4228_0000);
    tick(1);
    req0_start = 1'b0;
    tick(5);

    c = cyc;
    req0_dataa = 32'h3FC0_0000;
    req1_dataa = 32'h4120_0000;
    req0_start = 1'b1;
    req1_start = 1'b1;
    expect_on(0, 1, c + 4, 32'h4120_0000);
    expect_on(0, 0, c + 9, 32'h3F80_0000);
    expect_on(1, 0, c + 4, 32'h3F80_0000);
    expect_on(1, 1, c + 9, 32'h4120_0000);
    tick(1);
    req0_start = 1'b0;
    req1_start = 1'b0;
    tick(11);

    // A second start while pending is dropped; a start in the done cycle is taken.
    c = cyc;
    req0_dataa = 32'h40F8_0000;
    req0_start = 1'b1;
    expect_both(0, c + 4, 32'h40E0_0000);
    tick(1);
    req0_dataa = 32'h4120_0000;
    tick(1);
    req0_start = 1'b0;
    tick(2);
    req0_dataa = 32'h4120_0000;
    req0_start = 1'b1;
    expect_both(0, c + 9, 32'h4120_0000);
    tick(1);
    req0_start = 1'b0;
    tick(8);

    // Three disabled cycles during EXEC push the done out by three.
    c = cyc;
    req1_dataa = 32'h40F8_0000;
    req1_start = 1'b1;
    expect_both(1, c + LAT + 2 + 3, 32'h40E0_0000);
    tick(1);
    req1_start = 1'b0;
    tick(1);
    clk_en = 1'b0;
    tick(3);
    clk_en = 1'b1;
    tick(5);

    // A start presented only while disabled is never seen.
    clk_en = 1'b0;
    req0_dataa = 32'h4049_0FDB;
    req0_start = 1'b1;
    tick(1);
    req0_start = 1'b0;
    clk_en = 1'b1;
    tick(10);
    check("disabled_start_rr_busy", 32'(rr_busy), 32'h0);
    check("disabled_start_fp_busy", 32'(fp_busy), 32'h0);

    // Reset during EXEC discards the operation; a fresh one then runs normally.
    c = cyc;
    req0_dataa = 32'h4049_0FDB;
    req0_start = 1'b1;
    tick(1);
    req0_start = 1'b0;
    tick(1);
    reset_n = 1'b0;
    clear_model();
    #1;
    check_cleared("midop_reset");
    tick(1);
    reset_n = 1'b1;
    tick(8);
    c = cyc;
    req1_dataa = 32'h40F8_0000;
    req1_start = 1'b1;
    expect_both(1, c + LAT + 2, 32'h40E0_0000);
    tick(1);
    req1_start = 1'b0;
    tick(6);

    check("rr_queue_drained", 32'(q_rr.size()), 32'h0);
    check("fp_queue_drained", 32'(q_fp.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
